msrv32_regfile_sb: RTL



---
 rtl/msrv32_pkg.sv | 17 +
 rtl/msrv32_sb_popcount.sv | 30 +++
 rtl/msrv32_regfile_sb.sv | 133 +++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_pkg
// Description : Shared defaults for the msrv32 register file / scoreboard.
//               Register-address width is derived from the register count at
//               each use site with $clog2, so only the base sizes live here.
// Revision    : 1.0 - initial release
// ============================================================================
package msrv32_pkg;

    localparam int c_XLEN_DEF     = 32;    // data width of one register
    localparam int c_NREGS_DEF    = 32;    // architectural register count
    localparam int c_NRD_DEF      = 2;     // number of read ports
    localparam bit c_ZERO_REG_DEF = 1'b1;  // x0 hardwired to zero

endpackage : msrv32_pkg
`default_nettype wire

// File: rtl/msrv32_sb_popcount.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_sb_popcount
// Description : Population count of the scoreboard busy vector.
//   Ports:
//     vec_in    [N-1:0]  bit vector to count
//     count_out [OW-1:0] number of set bits in vec_in
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_sb_popcount #(
    parameter int N  = 32,
    parameter int OW = $clog2(N + 1)
) (
    input  logic [N-1:0]  vec_in,
    output logic [OW-1:0] count_out
);

    logic [OW-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + OW'(vec_in[i]);
        end
    end

    assign count_out = w_sum;

endmodule : msrv32_sb_popcount
`default_nettype wire

// File: rtl/msrv32_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_regfile_sb
// Description : Integer register file with NRD read ports, one write port,
//               same-cycle write-to-read forwarding, optional hardwired x0,
//               and a per-register busy scoreboard for long-latency producers.
//   Ports:
//     clk_in            clock
//     reset_in          asynchronous active-high reset
//     rs_addr_in        read addresses, port k at [k*AW +: AW]
//     rs_data_out       read data, port k at [k*XLEN +: XLEN] (combinational)
//     rs_busy_out       per-port source-pending flag (combinational)
//     wr_en_in          writeback enable
//     rd_addr_in        writeback address
//     rd_in             writeback data
//     rsv_en_in         reserve a destination at issue
//     rsv_addr_in       destination to reserve
//     rsv_conflict_out  reservation refused this cycle (WAW hazard)
//     flush_in          clear every busy bit at the next edge
//     busy_count_out    number of busy registers (current state)
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_regfile_sb
    import msrv32_pkg::*;
#(
    parameter int XLEN     = c_XLEN_DEF,
    parameter int NREGS    = c_NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = c_NRD_DEF,
    parameter bit ZERO_REG = c_ZERO_REG_DEF
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [NRD*AW-1:0]     rs_addr_in,
    output logic [NRD*XLEN-1:0]   rs_data_out,
    output logic [NRD-1:0]        rs_busy_out,
    input  logic                  wr_en_in,
    input  logic [AW-1:0]         rd_addr_in,
    input  logic [XLEN-1:0]       rd_in,
    input  logic                  rsv_en_in,
    input  logic [AW-1:0]         rsv_addr_in,
    output logic                  rsv_conflict_out,
    input  logic                  flush_in,
    output logic [AW:0]           busy_count_out
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic w_wr_ok;        // write targets a writable register
    logic w_rsv_ok;       // reservation targets a writable register
    logic w_rsv_wr_hit;   // writeback completes the register being reserved
    logic w_conflict;

    assign w_wr_ok      = wr_en_in  && (!ZERO_REG || (rd_addr_in  != '0));
    assign w_rsv_ok     = rsv_en_in && (!ZERO_REG || (rsv_addr_in != '0));
    assign w_rsv_wr_hit = wr_en_in  && (rd_addr_in == rsv_addr_in);

    // A pending producer on the destination refuses the reservation, unless
    // that producer is writing back right now: then the slot frees this cycle
    // and the new reservation can take it over.
    assign w_conflict       = w_rsv_ok && busy_q[rsv_addr_in] && !w_rsv_wr_hit;
    assign rsv_conflict_out = w_conflict;

    // Next-state data array.
    always_comb begin
        regs_d = regs_q;
        if (w_wr_ok) begin
            regs_d[rd_addr_in] = rd_in;
        end
    end

    // Next-state busy vector. Order matters: the reservation set follows the
    // write clear so a same-address write+reserve leaves the register busy,
    // and flush overrides everything.
    always_comb begin
        busy_d = busy_q;
        if (w_wr_ok) begin
            busy_d[rd_addr_in] = 1'b0;
        end
        if (w_rsv_ok && !w_conflict) begin
            busy_d[rsv_addr_in] = 1'b1;
        end
        if (flush_in) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports with writeback forwarding.
    for (genvar k = 0; k < NRD; k++) begin : g_rd_port
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;

        assign w_addr = rs_addr_in[k*AW +: AW];

        always_comb begin
            w_data = regs_q[w_addr];
            if (w_wr_ok && (rd_addr_in == w_addr)) begin
                w_data = rd_in;
            end
            if (ZERO_REG && (w_addr == '0)) begin
                w_data = '0;
            end
        end

        assign rs_data_out[k*XLEN +: XLEN] = w_data;
        assign rs_busy_out[k] = busy_q[w_addr] && !(wr_en_in && (rd_addr_in == w_addr));
    end

    msrv32_sb_popcount #(
        .N  (NREGS),
        .OW (AW + 1)
    ) u_popcount (
        .vec_in    (busy_q),
        .count_out (busy_count_out)
    );

endmodule : msrv32_regfile_sb
`default_nettype wire
